// File: rtl/writeback_stage_if.sv
// MEM/WB stage bus: MEM-side capture inputs and Decode-side write-back/bypass outputs.
// The stage itself uses the slave view; the MEM stage (or bench) uses the master view.
interface writeback_stage_if;
   logic        in_valid;
   logic        stall;
   logic        flush;
   logic [31:0] alu_result;
   logic [31:0] mem_read_data;
   logic [9:0]  ic_in;
   logic [2:0]  wb_ctrl_in;
   logic [31:0] wd_out;
   logic [9:0]  ic_out;
   logic [1:0]  wb_control_out;
   logic [4:0]  wb_dest;
   logic        byp_valid;
   logic [4:0]  byp_reg;
   logic [31:0] byp_data;
   logic [15:0] retire_count;

   modport master (
      output in_valid, stall, flush, alu_result, mem_read_data, ic_in, wb_ctrl_in,
      input  wd_out, ic_out, wb_control_out, wb_dest, byp_valid, byp_reg, byp_data,
             retire_count
   );

   modport slave (
      input  in_valid, stall, flush, alu_result, mem_read_data, ic_in, wb_ctrl_in,
      output wd_out, ic_out, wb_control_out, wb_dest, byp_valid, byp_reg, byp_data,
             retire_count
   );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB register + write-back: outputs valid one cycle after capture, bypass one cycle after the write.
// stall holds the entry (a held instruction writes once), flush inserts a bubble and beats stall.
module writeback_stage (
   input  logic              clk,
   input  logic              reset,
   writeback_stage_if.slave  wb
);
   logic        valid_q;
   logic        done_q;
   logic [31:0] alu_q;
   logic [31:0] mem_q;
   logic [9:0]  ic_q;
   logic [2:0]  ctrl_q;
   logic        byp_valid_q;
   logic [4:0]  byp_reg_q;
   logic [31:0] byp_data_q;
   logic [15:0] retire_q;

   logic [4:0]  dest;
   logic [31:0] wd;
   logic        commit;

   always_comb begin
      dest   = ctrl_q[1] ? ic_q[9:5] : ic_q[4:0];
      wd     = ctrl_q[2] ? mem_q : alu_q;
      // Writes to $0 are dropped here so they never reach the bypass or the counter.
      commit = valid_q & ctrl_q[0] & ~done_q & (dest != 5'd0);
   end

   assign wb.wd_out         = wd;
   assign wb.ic_out         = ic_q;
   assign wb.wb_control_out = {ctrl_q[1], commit};
   assign wb.wb_dest        = dest;
   assign wb.byp_valid      = byp_valid_q;
   assign wb.byp_reg        = byp_reg_q;
   assign wb.byp_data       = byp_data_q;
   assign wb.retire_count   = retire_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         alu_q       <= '0;
         mem_q       <= '0;
         ic_q        <= '0;
         ctrl_q      <= '0;
         byp_valid_q <= 1'b0;
         byp_reg_q   <= '0;
         byp_data_q  <= '0;
         retire_q    <= '0;
      end else begin
         if (wb.flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
         end else if (wb.stall) begin
            // Remember that the held instruction already wrote, so it cannot write again.
            if (commit)
               done_q <= 1'b1;
         end else begin
            valid_q <= wb.in_valid;
            alu_q   <= wb.alu_result;
            mem_q   <= wb.mem_read_data;
            ic_q    <= wb.ic_in;
            ctrl_q  <= wb.wb_ctrl_in;
            done_q  <= 1'b0;
         end

         if (commit) begin
            byp_valid_q <= 1'b1;
            byp_reg_q   <= dest;
            byp_data_q  <= wd;
            retire_q    <= retire_q + 16'd1;
         end else begin
            byp_valid_q <= 1'b0;
         end
      end
   end
endmodule
